// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests: detects completion by end-PC match and/or tohost store,
// then latches pass/fail/timeout, the failing test number and the elapsed run-cycle count.
module riscv_test_monitor #(
    parameter int unsigned           XLEN         = 32,
    parameter int unsigned           MODE         = 0,
    parameter logic [XLEN-1:0]       END_PC       = 'h44,
    parameter int unsigned           MATCH_CYCLES = 1,
    parameter logic [XLEN-1:0]       TOHOST_ADDR  = 'h1000,
    parameter int unsigned           TIMEOUT      = 6000,
    parameter int unsigned           CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  gp,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-2:0]  test_num,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic {RUN, DONE} state_t;

    localparam bit               PC_EN    = (MODE == 0) || (MODE == 2);
    localparam bit               TH_EN    = (MODE == 1) || (MODE == 2);
    localparam logic [7:0]       MATCH_LAST = 8'(MATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t           state, state_d;
    logic [7:0]       match_cnt, match_cnt_d;
    logic             done_d, pass_d, fail_d, timeout_d;
    logic [XLEN-2:0]  test_num_d;
    logic [CNT_W-1:0] cycles_d;

    logic             pc_hit, pc_miss, pc_evt, th_evt, evt;
    logic [XLEN-1:0]  result;

    // Data inputs only matter under their valid qualifier, so X on an idle bus never propagates.
    always_comb begin
        pc_hit  = PC_EN && pc_valid && (pc == END_PC);
        pc_miss = PC_EN && pc_valid && (pc != END_PC);
        pc_evt  = pc_hit && (match_cnt == MATCH_LAST);
        th_evt  = TH_EN && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
        evt     = pc_evt || th_evt;
        result  = th_evt ? st_data : gp;
    end

    // NOTE: every output of this block gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        match_cnt_d = match_cnt;
        done_d      = done;
        pass_d      = pass;
        fail_d      = fail;
        timeout_d   = timeout;
        test_num_d  = test_num;
        cycles_d    = cycles;

        if (state == RUN) begin
            cycles_d = (cycles == '1) ? cycles : cycles + CNT_W'(1);

            if (pc_hit && match_cnt != 8'hFF)
                match_cnt_d = match_cnt + 8'd1;
            else if (pc_miss)
                match_cnt_d = '0;

            // A completion event in the final cycle outranks the timeout.
            if (evt) begin
                state_d = DONE;
                done_d  = 1'b1;
                if (result == XLEN'(1)) begin
                    pass_d     = 1'b1;
                    test_num_d = '0;
                end else begin
                    fail_d     = 1'b1;
                    test_num_d = result[XLEN-1:1];
                end
            end else if (cycles == TO_LAST) begin
                state_d   = DONE;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            match_cnt <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            test_num  <= '0;
            cycles    <= '0;
        end else begin
            state     <= state_d;
            match_cnt <= match_cnt_d;
            done      <= done_d;
            pass      <= pass_d;
            fail      <= fail_d;
            timeout   <= timeout_d;
            test_num  <= test_num_d;
            cycles    <= cycles_d;
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: four instances in different modes share one stimulus bus,
// and each scenario resets them all and checks the instance it targets.
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] gp = '0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;

    logic [3:0]  done_v, pass_v, fail_v, timeout_v;
    logic [30:0] tn_v  [4];
    logic [31:0] cyc_v [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    riscv_test_monitor #(.MODE(0), .MATCH_CYCLES(1), .TIMEOUT(20)) u0 (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .gp(gp),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .timeout(timeout_v[0]),
        .test_num(tn_v[0]), .cycles(cyc_v[0]));

    riscv_test_monitor #(.MODE(0), .MATCH_CYCLES(3), .TIMEOUT(20)) u1 (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .gp(gp),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .timeout(timeout_v[1]),
        .test_num(tn_v[1]), .cycles(cyc_v[1]));

    riscv_test_monitor #(.MODE(2), .MATCH_CYCLES(1), .TIMEOUT(20)) u2 (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .gp(gp),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .timeout(timeout_v[2]),
        .test_num(tn_v[2]), .cycles(cyc_v[2]));

    riscv_test_monitor #(.MODE(1)) u3 (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .gp(gp),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(done_v[3]), .pass(pass_v[3]), .fail(fail_v[3]), .timeout(timeout_v[3]),
        .test_num(tn_v[3]), .cycles(cyc_v[3]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Outputs are sampled 1 ns after the edge; inputs are also changed there, well before the next edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        pc_valid = 1'b0; pc = 'x; gp = 'x;
        st_valid = 1'b0; st_addr = 'x; st_data = 'x;
    endtask

    task automatic drive_pc(input logic [31:0] p, input logic [31:0] g);
        pc_valid = 1'b1; pc = p; gp = g;
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_addr = a; st_data = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic check_all(input string tag, input int k, input logic d, input logic p,
                             input logic f, input logic t, input logic [30:0] tn,
                             input logic [31:0] cyc);
        check({tag, ".done"},     done_v[k],    d);
        check({tag, ".pass"},     pass_v[k],    p);
        check({tag, ".fail"},     fail_v[k],    f);
        check({tag, ".timeout"},  timeout_v[k], t);
        check({tag, ".test_num"}, tn_v[k],      tn);
        check({tag, ".cycles"},   cyc_v[k],     cyc);
    endtask

    initial begin
        // Reset state and basic pass one cycle after the end-PC sample.
        do_reset();
        check_all("rst", 0, 0, 0, 0, 0, 0, 0);
        drive_pc(32'h40, 32'h1);
        step();
        check_all("pc40", 0, 0, 0, 0, 0, 0, 1);
        drive_pc(32'h44, 32'h1);
        step();
        check_all("pass", 0, 1, 1, 0, 0, 0, 2);
        drive_pc(32'h44, 32'h5);
        drive_st(32'h1000, 32'h3);
        step(3);
        check_all("pass_hold", 0, 1, 1, 0, 0, 0, 2);

        // gp = 0xB -> fail, test 5.
        do_reset();
        drive_pc(32'h44, 32'hB);
        step();
        check_all("fail5", 0, 1, 0, 1, 0, 5, 1);

        // gp = 0 counts as fail with test number 0.
        do_reset();
        drive_pc(32'h44, 32'h0);
        step();
        check_all("fail0", 0, 1, 0, 1, 0, 0, 1);

        // MATCH_CYCLES=3 with bubble and a non-matching PC breaking the run.
        do_reset();
        begin
            logic [31:0] seq [7] = '{32'h44, 32'h44, 32'h0, 32'h48, 32'h44, 32'h44, 32'h44};
            for (int i = 0; i < 7; i++) begin
                if (i == 2) idle();
                else begin
                    st_valid = 1'b0;
                    drive_pc(seq[i], 32'h1);
                end
                step();
                check($sformatf("mc3_seq%0d.done", i), done_v[1], (i == 6));
            end
        end
        check_all("mc3", 1, 1, 1, 0, 0, 0, 7);

        // A bubble only holds the count: 0x44, 0x44, bubble, 0x44 completes.
        do_reset();
        drive_pc(32'h44, 32'h1);
        step(2);
        idle();
        step();
        check("mc3_hold.pre", done_v[1], 1'b0);
        drive_pc(32'h44, 32'h1);
        step();
        check("mc3_hold.done", done_v[1], 1'b1);

        // MODE 2: simultaneous events, tohost data wins.
        do_reset();
        drive_st(32'h1000, 32'h6);
        drive_pc(32'h40, 32'h1);
        step();
        check("m2_even_store.done", done_v[2], 1'b0);
        drive_pc(32'h44, 32'h1);
        drive_st(32'h1000, 32'h7);
        step();
        check_all("m2_prio", 2, 1, 0, 1, 0, 3, 2);

        // MODE 1: end PC and non-tohost/even stores are ignored.
        do_reset();
        drive_pc(32'h44, 32'h1);
        step();
        check("m1_pc_ignored", done_v[3], 1'b0);
        drive_st(32'h1000, 32'h0);
        step();
        check("m1_even_ignored", done_v[3], 1'b0);
        drive_st(32'h1004, 32'h1);
        step();
        check("m1_addr_ignored", done_v[3], 1'b0);
        drive_st(32'h1000, 32'h1);
        step();
        check_all("m1_pass", 3, 1, 1, 0, 0, 0, 4);

        // Timeout at TIMEOUT=20 and hold afterwards.
        do_reset();
        step(19);
        check_all("to_pre", 0, 0, 0, 0, 0, 0, 19);
        step();
        check_all("to", 0, 1, 0, 0, 1, 0, 20);
        step(4);
        check_all("to_hold", 0, 1, 0, 0, 1, 0, 20);

        // Completion in the last cycle beats timeout.
        do_reset();
        step(19);
        drive_pc(32'h44, 32'h1);
        step();
        check_all("to_race", 0, 1, 1, 0, 0, 0, 20);

        // Reset out of DONE, reset mid-RUN, then a clean pass.
        idle();
        rst = 1'b0;
        step();
        check_all("rst_done", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(5);
        check("midrun.cycles", cyc_v[0], 32'd5);
        rst = 1'b0;
        step();
        check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive_pc(32'h44, 32'h1);
        step();
        check_all("after_rst", 0, 1, 1, 0, 0, 0, 1);

        // Reset mid-RUN clears the match count.
        do_reset();
        drive_pc(32'h44, 32'h1);
        step(2);
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive_pc(32'h44, 32'h1);
        step(2);
        check("mc3_rst.pre", done_v[1], 1'b0);
        step();
        check("mc3_rst.done", done_v[1], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
Synthesizable end-of-test monitor for the pipelined RV32 core running riscv-tests (rv32ui-p-* suite). It watches the fetch PC, the gp (x3) register value and data-memory stores, and detects test completion by end-PC match, tohost store, or both. It reports pass, fail with the failing test number, or timeout. The monitor replaces per-test hard-coded benches with one parametrised block; bench code only samples its outputs.

Parameters:
XLEN, 32, data/address width.
MODE, 0, detection mode: 0 = end-PC watch, 1 = tohost-store watch, 2 = both (first event wins).
END_PC, 32'h44, PC value that marks test end.
MATCH_CYCLES, 1, consecutive valid end-PC samples required before evaluation (1..255); absorbs pipeline stalls and flushes.
TOHOST_ADDR, 32'h1000, store address treated as tohost.
TIMEOUT, 6000, run-cycle limit before a timeout is declared (>=2).
CNT_W, 32, cycle-counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low (0 = reset).
pc_valid  in  1  pc holds a real fetch this cycle (not a stall or bubble).
pc  in  XLEN  fetch-stage PC.
gp  in  XLEN  current value of register x3.
st_valid  in  1  a data-memory store commits this cycle.
st_addr  in  XLEN  store address.
st_data  in  XLEN  store data.
done  out  1  sticky; test has finished (pass, fail or timeout).
pass  out  1  sticky; result value == 1.
fail  out  1  sticky; result value != 1.
timeout  out  1  sticky; TIMEOUT reached with no completion.
test_num  out  XLEN-1  failing test number = result >> 1; 0 unless fail.
cycles  out  CNT_W  run cycles elapsed; frozen at done.

Behaviour:
- Reset (rst==0 at posedge): state RUN; done, pass, fail, timeout = 0; test_num = 0; cycles = 0; match_cnt = 0. Reset mid-run or after DONE fully restarts the monitor.
- States: RUN and DONE. DONE exits only through reset.
- RUN: cycles increments by 1 on every clock and saturates at all-ones.
- PC detection (MODE 0 or 2):
  - pc_valid && pc==END_PC: match_cnt increments.
  - pc_valid && pc!=END_PC: match_cnt clears to 0.
  - !pc_valid: match_cnt holds.
  - A PC completion event occurs on the matching sample that brings the match count to MATCH_CYCLES.
  - Result value = gp sampled that same cycle.
- tohost detection (MODE 1 or 2):
  - st_valid && st_addr==TOHOST_ADDR && st_data[0]==1 is a completion event; result value = st_data.
  - Stores to tohost with st_data[0]==0 are ignored.
- Simultaneous events in MODE 2: tohost has priority, and its st_data is the result value.
- Evaluation at a completion event: next posedge enters DONE, with done = 1 and exactly one of pass/fail set.
  - Result == 1: pass = 1, test_num = 0.
  - Result != 1: fail = 1, test_num = result[XLEN-1:1]. Result == 0 also counts as fail, with test_num = 0.
  - Latency is one cycle from the event sample to done high.
- Timeout: if cycles == TIMEOUT-1 in RUN and no completion event occurs that cycle, the next posedge enters DONE with done = 1, timeout = 1, pass = fail = 0. A completion event in that same cycle wins over timeout.
- DONE: all outputs hold, all inputs are ignored, cycles is frozen.
- X-safety: pc, gp and st_* are only examined when their valid qualifier is high.

Test Plan:
- MODE=0, MATCH_CYCLES=1: drive pc_valid=1, pc=0x40 and then 0x44 with gp=1 -> done=1 and pass=1 one cycle after the 0x44 sample; test_num=0; cycles frozen.
- MODE=0, gp=0x0000000B at the end PC -> fail=1, test_num=5, pass=0, timeout=0.
- MODE=0, MATCH_CYCLES=3: sequence 0x44, 0x44, bubble (pc_valid=0), 0x48, 0x44, 0x44, 0x44 with gp=1 -> no done until the third consecutive valid 0x44; done the following cycle.
- MODE=2: in one cycle drive pc=0x44 with gp=1 and a store to 0x1000 with data 0x7 -> fail=1, test_num=3 (tohost priority).
- TIMEOUT=20, no events -> done=1, timeout=1, pass=fail=0 at the posedge after cycles==19; a completion event arriving exactly at cycles==19 -> pass or fail instead, timeout=0.
- Drop rst low for one cycle while in DONE and again mid-RUN -> all outputs return to 0 the next cycle; a later pass sequence is detected correctly.
